// File: rtl/ni_packetizer_if.sv
// ni_packetizer_if: descriptor, payload and flit handshakes between agent, packetizer and router
interface ni_packetizer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int TYPE_WIDTH = 2,
   parameter int DEST_WIDTH = 2,
   parameter int LEN_WIDTH = 4
);
   logic [DEST_WIDTH-1:0] msg_dest;
   logic [LEN_WIDTH-1:0] msg_len;
   logic msg_valid;
   logic msg_ready;
   logic [DATA_WIDTH-TYPE_WIDTH-1:0] pld_data;
   logic pld_valid;
   logic pld_ready;
   logic [DATA_WIDTH-1:0] flit_data;
   logic flit_valid;
   logic flit_ready;
   modport slave (
      input msg_dest, msg_len, msg_valid, pld_data, pld_valid, flit_ready,
      output msg_ready, pld_ready, flit_data, flit_valid
   );
   modport master (
      output msg_dest, msg_len, msg_valid, pld_data, pld_valid, flit_ready,
      input msg_ready, pld_ready, flit_data, flit_valid
   );
endinterface

// File: rtl/ni_packetizer.sv
// ni_packetizer: turns descriptors plus payload words into head/body/tail wormhole flits
module ni_packetizer #(
   parameter int N = 4,
   parameter int INDEX = 0,
   parameter int DATA_WIDTH = 64,
   parameter int TYPE_WIDTH = 2,
   parameter int FlitPerPacket = 16,
   parameter int DEST_WIDTH = $clog2(N),
   parameter int LEN_WIDTH = $clog2(FlitPerPacket)
) (
   input  logic clk,
   input  logic rst,
   ni_packetizer_if.slave m,
   output logic [15:0] pkt_count,
   output logic len_err
);
   localparam logic [TYPE_WIDTH-1:0] HEAD = TYPE_WIDTH'(1);
   localparam logic [TYPE_WIDTH-1:0] BODY = TYPE_WIDTH'(2);
   localparam logic [TYPE_WIDTH-1:0] TAIL = TYPE_WIDTH'(3);
   localparam int PAD = DATA_WIDTH - TYPE_WIDTH - 2 * DEST_WIDTH - LEN_WIDTH;
   localparam logic [DEST_WIDTH-1:0] SRC = DEST_WIDTH'(INDEX);
   typedef enum logic {IDLE, PAYLOAD} state_t;
   state_t state, state_n;
   logic [LEN_WIDTH-1:0] remaining, remaining_n, len_eff;
   logic [DATA_WIDTH-1:0] flit_n;
   logic load, take, is_tail, zero_len;
   assign load = !m.flit_valid || m.flit_ready;
   assign zero_len = m.msg_len == '0;
   assign len_eff = zero_len ? LEN_WIDTH'(1) : m.msg_len;
   assign is_tail = remaining == LEN_WIDTH'(1);
   always_comb begin
      state_n = state;
      remaining_n = remaining;
      take = 1'b0;
      flit_n = '0;
      m.msg_ready = 1'b0;
      m.pld_ready = 1'b0;
      if (state == IDLE) begin
         m.msg_ready = load;
         if (m.msg_valid && load) begin
            take = 1'b1;
            flit_n = {HEAD, m.msg_dest, SRC, len_eff, {PAD{1'b0}}};
            remaining_n = len_eff;
            state_n = PAYLOAD;
         end
      end else begin
         m.pld_ready = load;
         if (m.pld_valid && load) begin
            take = 1'b1;
            flit_n = {is_tail ? TAIL : BODY, m.pld_data};
            remaining_n = remaining - LEN_WIDTH'(1);
            state_n = is_tail ? IDLE : PAYLOAD;
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         remaining <= '0;
         m.flit_valid <= 1'b0;
         m.flit_data <= '0;
         pkt_count <= '0;
         len_err <= 1'b0;
      end else begin
         state <= state_n;
         remaining <= remaining_n;
         if (load) m.flit_valid <= take;
         if (take) m.flit_data <= flit_n;
         if (m.flit_valid && m.flit_ready && m.flit_data[DATA_WIDTH-1 -: TYPE_WIDTH] == TAIL)
            pkt_count <= pkt_count + 16'd1;
         if (state == IDLE && m.msg_valid && load && zero_len) len_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: directed packet sequences checked against hand-computed flits
module tb_ni_packetizer;
   logic clk = 0;
   logic rst = 0;
   logic [15:0] pkt_count;
   logic len_err;
   int errors = 0;
   int checks = 0;
   int cycle = 0;
   logic [63:0] got[$];
   int cyc[$];
   ni_packetizer_if #(.DATA_WIDTH(64), .TYPE_WIDTH(2), .DEST_WIDTH(2), .LEN_WIDTH(4)) bus ();
   ni_packetizer dut (.clk(clk), .rst(rst), .m(bus), .pkt_count(pkt_count), .len_err(len_err));
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;
   always @(negedge clk)
      if (rst && bus.flit_valid && bus.flit_ready) begin
         got.push_back(bus.flit_data);
         cyc.push_back(cycle);
      end
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic send_msg(input logic [1:0] d, input logic [3:0] l);
      bit ok = 0;
      bus.msg_dest = d;
      bus.msg_len = l;
      bus.msg_valid = 1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = bus.msg_ready;
         @(posedge clk);
         #1;
      end
      bus.msg_valid = 0;
      if (!ok) chk("msg_timeout", 0, 1);
   endtask
   task automatic send_pld(input logic [61:0] w);
      bit ok = 0;
      bus.pld_data = w;
      bus.pld_valid = 1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = bus.pld_ready;
         @(posedge clk);
         #1;
      end
      bus.pld_valid = 0;
      if (!ok) chk("pld_timeout", 0, 1);
   endtask
   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = !bus.flit_valid;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("drain_timeout", 0, 1);
   endtask
   task automatic run_pkt(input logic [1:0] d, input logic [3:0] l, input int base, input int n);
      got.delete();
      cyc.delete();
      fork
         send_msg(d, l);
         begin
            for (int i = 0; i < n; i++) send_pld(62'(base + i));
         end
      join
      drain();
   endtask
   task automatic check_pkt(input string tag, input logic [63:0] head, input int base, input int n, input int span);
      chk({tag, "_nflits"}, 64'(got.size()), 64'(n + 1));
      if (got.size() == n + 1) begin
         chk({tag, "_head"}, got[0], head);
         for (int i = 1; i <= n; i++)
            chk({tag, "_flit"}, got[i], {(i == n) ? 2'b11 : 2'b10, 62'(base + i - 1)});
         chk({tag, "_span"}, 64'(cyc[n] - cyc[0]), 64'(span));
      end
   endtask
   initial begin
      bus.msg_valid = 0;
      bus.msg_dest = 0;
      bus.msg_len = 0;
      bus.pld_valid = 0;
      bus.pld_data = 0;
      bus.flit_ready = 1;
      @(negedge clk);
      chk("rst_flit_valid", 64'(bus.flit_valid), 0);
      chk("rst_flit_data", bus.flit_data, 0);
      chk("rst_pkt_count", 64'(pkt_count), 0);
      chk("rst_len_err", 64'(len_err), 0);
      @(posedge clk);
      #1 rst = 1;
      @(negedge clk);
      chk("post_rst_msg_ready", 64'(bus.msg_ready), 1);
      chk("post_rst_pld_ready", 64'(bus.pld_ready), 0);
      @(posedge clk);
      #1;
      // basic: dest 3, len 3, payloads A..C on four consecutive cycles
      run_pkt(2'd3, 4'd3, 'hA, 3);
      check_pkt("basic", 64'h70C0_0000_0000_0000, 'hA, 3, 3);
      chk("basic_pkt_count", 64'(pkt_count), 1);
      // backpressure: stall three cycles while the second body waits
      got.delete();
      cyc.delete();
      fork
         send_msg(2'd2, 4'd4);
         begin
            for (int i = 0; i < 4; i++) send_pld(62'('h201 + i));
         end
         begin
            bit seen = 0;
            for (int i = 0; i < 60 && !seen; i++) begin
               @(posedge clk);
               #1;
               seen = bus.flit_valid && bus.flit_data == 64'h8000_0000_0000_0202;
            end
            chk("bp_seen", 64'(seen), 1);
            if (seen) begin
               bus.flit_ready = 0;
               for (int k = 0; k < 3; k++) begin
                  @(negedge clk);
                  chk("bp_hold_data", bus.flit_data, 64'h8000_0000_0000_0202);
                  chk("bp_pld_ready", 64'(bus.pld_ready), 0);
                  chk("bp_msg_ready", 64'(bus.msg_ready), 0);
                  @(posedge clk);
                  #1;
               end
               bus.flit_ready = 1;
            end
         end
      join
      drain();
      check_pkt("bp", 64'h6100_0000_0000_0000, 'h201, 4, 7);
      chk("bp_pkt_count", 64'(pkt_count), 2);
      // back-to-back len 1 then len 15 with no idle cycle
      got.delete();
      cyc.delete();
      fork
         begin
            send_msg(2'd1, 4'd1);
            send_msg(2'd0, 4'd15);
         end
         begin
            for (int i = 0; i < 16; i++) send_pld(62'('h100 + i));
         end
      join
      drain();
      chk("b2b_nflits", 64'(got.size()), 18);
      if (got.size() == 18) begin
         chk("b2b_head1", got[0], 64'h5040_0000_0000_0000);
         chk("b2b_tail1", got[1], 64'hC000_0000_0000_0100);
         chk("b2b_head2", got[2], 64'h43C0_0000_0000_0000);
         for (int i = 3; i < 17; i++) chk("b2b_body", got[i], {2'b10, 62'('h100 + i - 2)});
         chk("b2b_tail2", got[17], 64'hC000_0000_0000_010F);
         chk("b2b_span", 64'(cyc[17] - cyc[0]), 17);
      end
      chk("b2b_pkt_count", 64'(pkt_count), 4);
      // zero length goes out as len 1 and latches the error flag
      run_pkt(2'd1, 4'd0, 'h77, 1);
      check_pkt("len0", 64'h5040_0000_0000_0000, 'h77, 1, 1);
      chk("len0_err", 64'(len_err), 1);
      run_pkt(2'd3, 4'd2, 'h88, 2);
      check_pkt("after_len0", 64'h7080_0000_0000_0000, 'h88, 2, 2);
      chk("len_err_sticky", 64'(len_err), 1);
      chk("len0_pkt_count", 64'(pkt_count), 6);
      // reset after head plus two bodies of a len 5 packet
      fork
         send_msg(2'd2, 4'd5);
         begin
            send_pld(62'h301);
            send_pld(62'h302);
         end
      join
      @(negedge clk);
      rst = 0;
      #1;
      chk("midrst_flit_valid", 64'(bus.flit_valid), 0);
      chk("midrst_pkt_count", 64'(pkt_count), 0);
      chk("midrst_flit_data", bus.flit_data, 0);
      @(posedge clk);
      #1 rst = 1;
      @(negedge clk);
      chk("midrst_msg_ready", 64'(bus.msg_ready), 1);
      chk("midrst_pld_ready", 64'(bus.pld_ready), 0);
      @(posedge clk);
      #1;
      run_pkt(2'd2, 4'd1, 'h55, 1);
      check_pkt("midrst_pkt", 64'h6040_0000_0000_0000, 'h55, 1, 1);
      chk("midrst_pkt_count1", 64'(pkt_count), 1);
      // wrap: preload near the top instead of sending 65536 packets
      force dut.pkt_count = 16'hFFFE;
      @(negedge clk);
      release dut.pkt_count;
      @(posedge clk);
      #1;
      run_pkt(2'd1, 4'd1, 'h11, 1);
      chk("wrap_ffff", 64'(pkt_count), 64'hFFFF);
      run_pkt(2'd1, 4'd1, 'h12, 1);
      chk("wrap_zero", 64'(pkt_count), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
